iserdes_word_aligner: RTL

// - Per-channel word aligner for NUM_CH deserialised lanes from ISERDESE2 instances (NETWORKING mode, CLKDIV domain).
// - During training it compares each lane's word against TRAIN_PATTERN and pulses that lane's BITSLIP until the pattern holds.
// - Each lane then reports lock and forwards registered data with a valid flag.
// - Sits between the ISERDESE2 bank and user logic.

---
 rtl/iserdes_align_pkg.sv | 22 ++
 rtl/iserdes_align_lane.sv | 151 +++++++++++++++
 rtl/iserdes_word_aligner.sv | 58 +++++
 3 files changed

// File: rtl/iserdes_align_pkg.sv
// Shared types and helpers for the ISERDES word aligner.
package iserdes_align_pkg;

    // Per-lane alignment state
    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SLIP,
        WAIT,
        LOCKED,
        FAIL
    } state_t;

    // Widest word the TRAIN_PATTERN parameter can carry
    localparam int MAX_DATA_WIDTH = 64;

    // Bits needed for a counter that must reach n inclusive
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/iserdes_align_lane.sv
// One lane of the word aligner: input/output registers, training FSM,
// match/wait/slip counters and the bitslip request.
// Optional LOSS_OF_LOCK_EN: a mismatch while locked and training drops lock
// and resumes searching from the current slip position.
module iserdes_align_lane
    import iserdes_align_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] PATTERN     = 8'h5C,
    parameter int                    MATCH_COUNT = 16,
    parameter int                    SLIP_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_train,
    input  logic                  i_train_rise,
    input  logic [DATA_WIDTH-1:0] i_din,
    output logic                  o_bitslip,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_dout_valid,
    output logic                  o_locked,
    output logic                  o_align_err
);

    localparam int MC_W = cnt_w(MATCH_COUNT);
    localparam int SW_W = cnt_w(SLIP_WAIT);
    localparam int SC_W = cnt_w(DATA_WIDTH);

    state_t                r_state, w_state_nxt;
    logic [MC_W-1:0]       r_match_cnt, w_match_nxt;
    logic [SW_W-1:0]       r_wait_cnt, w_wait_nxt;
    logic [SC_W-1:0]       r_slip_cnt, w_slip_nxt;
    logic                  r_align_err, w_align_err_nxt;
    logic [DATA_WIDTH-1:0] r_din_q, r_dout;
    logic                  w_match;

    assign w_match = (r_din_q == PATTERN);

    // Two-stage data path: din_q feeds the comparator, dout follows one cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_din_q <= '0;
            r_dout  <= '0;
        end else begin
            r_din_q <= i_din;
            r_dout  <= r_din_q;
        end
    end

    // FSM state and counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_match_cnt <= '0;
            r_wait_cnt  <= '0;
            r_slip_cnt  <= '0;
            r_align_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_match_cnt <= w_match_nxt;
            r_wait_cnt  <= w_wait_nxt;
            r_slip_cnt  <= w_slip_nxt;
            r_align_err <= w_align_err_nxt;
        end
    end

    // Next-state and counter updates; slip_cnt stops at DATA_WIDTH because
    // reaching it routes a mismatch to FAIL instead of another SLIP
    always_comb begin
        w_state_nxt     = r_state;
        w_match_nxt     = r_match_cnt;
        w_wait_nxt      = r_wait_cnt;
        w_slip_nxt      = r_slip_cnt;
        w_align_err_nxt = r_align_err;
        case (r_state)
            IDLE: begin
                if (i_train) begin
                    w_state_nxt     = CHECK;
                    w_match_nxt     = '0;
                    w_wait_nxt      = '0;
                    w_slip_nxt      = '0;
                    w_align_err_nxt = 1'b0;
                end
            end
            CHECK: begin
                if (!i_train) begin
                    w_state_nxt = IDLE;
                end else if (w_match) begin
                    w_match_nxt = r_match_cnt + 1'b1;
                    if (r_match_cnt == MC_W'(MATCH_COUNT - 1))
                        w_state_nxt = LOCKED;
                end else begin
                    w_match_nxt = '0;
                    if (r_slip_cnt == SC_W'(DATA_WIDTH)) begin
                        w_state_nxt     = FAIL;
                        w_align_err_nxt = 1'b1;
                    end else begin
                        w_state_nxt = SLIP;
                    end
                end
            end
            SLIP: begin
                if (!i_train) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_slip_nxt  = r_slip_cnt + 1'b1;
                    w_wait_nxt  = '0;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (!i_train) begin
                    w_state_nxt = IDLE;
                end else if (r_wait_cnt == SW_W'(SLIP_WAIT - 1)) begin
                    w_wait_nxt  = '0;
                    w_state_nxt = CHECK;
                end else begin
                    w_wait_nxt = r_wait_cnt + 1'b1;
                end
            end
            LOCKED: begin
                if (i_train_rise) begin
                    w_state_nxt     = CHECK;
                    w_match_nxt     = '0;
                    w_wait_nxt      = '0;
                    w_slip_nxt      = '0;
                    w_align_err_nxt = 1'b0;
                end
`ifdef LOSS_OF_LOCK_EN
                else if (i_train && !w_match) begin
                    w_state_nxt = CHECK;
                    w_match_nxt = '0;
                end
`endif
            end
            FAIL: begin
                if (!i_train)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Gating with train keeps a falling train from issuing a slip
    assign o_bitslip    = (r_state == SLIP) && i_train;
    assign o_locked     = (r_state == LOCKED);
    assign o_dout_valid = (r_state == LOCKED);
    assign o_align_err  = r_align_err;
    assign o_dout       = r_dout;

endmodule

// File: rtl/iserdes_word_aligner.sv
// Word aligner for NUM_CH ISERDESE2 lanes in the CLKDIV domain. Each lane
// bitslips independently until its words equal TRAIN_PATTERN for
// MATCH_COUNT consecutive cycles, then reports lock and forwards data.
// Optional LOSS_OF_LOCK_EN: mismatch while locked and training drops lock.
module iserdes_word_aligner
    import iserdes_align_pkg::*;
#(
    parameter int                        NUM_CH        = 1,
    parameter int                        DATA_WIDTH    = 8,
    parameter logic [MAX_DATA_WIDTH-1:0] TRAIN_PATTERN = 64'h5C,
    parameter int                        MATCH_COUNT   = 16,
    parameter int                        SLIP_WAIT     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         train,
    input  logic [NUM_CH*DATA_WIDTH-1:0] din,
    output logic [NUM_CH-1:0]            bitslip,
    output logic [NUM_CH*DATA_WIDTH-1:0] dout,
    output logic [NUM_CH-1:0]            dout_valid,
    output logic [NUM_CH-1:0]            locked,
    output logic [NUM_CH-1:0]            align_err
);

    localparam logic [DATA_WIDTH-1:0] PAT = TRAIN_PATTERN[DATA_WIDTH-1:0];

    logic r_train_d;
    logic w_train_rise;

    // Previous train level for the shared retrain edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_train_d <= 1'b0;
        else     r_train_d <= train;
    end

    assign w_train_rise = train & ~r_train_d;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        iserdes_align_lane #(
            .DATA_WIDTH  (DATA_WIDTH),
            .PATTERN     (PAT),
            .MATCH_COUNT (MATCH_COUNT),
            .SLIP_WAIT   (SLIP_WAIT)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .i_train      (train),
            .i_train_rise (w_train_rise),
            .i_din        (din[g*DATA_WIDTH +: DATA_WIDTH]),
            .o_bitslip    (bitslip[g]),
            .o_dout       (dout[g*DATA_WIDTH +: DATA_WIDTH]),
            .o_dout_valid (dout_valid[g]),
            .o_locked     (locked[g]),
            .o_align_err  (align_err[g])
        );
    end

endmodule
